// File: rtl/accum_pkg.sv
// Shared types and constant helpers for the saturating block accumulator.
// Saturation limits are built wide here and trimmed to WIDTH at the use site.
package accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int SAT_W = 64;

  // Largest positive w-bit two's complement value, zero-extended to SAT_W.
  function automatic logic [SAT_W-1:0] sat_max(input int w);
    logic [SAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W; i++) begin
      if (i < w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Most negative w-bit two's complement value, zero-extended to SAT_W.
  function automatic logic [SAT_W-1:0] sat_min(input int w);
    logic [SAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W; i++) begin
      if (i == w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/Increment.sv
// Ripple-carry adder with signed overflow flag.
// overflow is the carry into the MSB differing from the carry out of it.
module Increment #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             overflow
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign overflow = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/accumulate_dump.sv
// Sums COUNT signed samples with saturation, then presents the block total
// until downstream takes it. dbg_state mirrors the FSM register.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and the result is held stable
// while out_valid is high and out_ready is low.
module accumulate_dump
  import accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output state_t           dbg_state
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);
  localparam logic [SAT_W-1:0] MAX_FULL = sat_max(WIDTH);
  localparam logic [SAT_W-1:0] MIN_FULL = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS = MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_NEG = MIN_FULL[WIDTH-1:0];

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;

  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] sum_next;

  Increment #(.WIDTH(WIDTH)) u_add (
    .a        (acc_q),
    .b        (in_data),
    .cin      (1'b0),
    .s        (sum),
    .overflow (ovf)
  );

  // Overflow direction follows the accumulator sign before the add.
  assign sum_next = ovf ? (acc_q[WIDTH-1] ? MIN_NEG : MAX_POS) : sum;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (cnt_q == LAST) begin
              out_data_d = sum_next;
              out_sat_d  = sat_q | ovf;
              acc_d      = '0;
              cnt_d      = '0;
              sat_d      = 1'b0;
              state_d    = HOLD;
            end else begin
              acc_d = sum_next;
              cnt_d = cnt_q + CNT_W'(1);
              sat_d = sat_q | ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign dbg_state = state_q;

endmodule

// File: doc/accumulate_dump.md
# accumulate_dump

Block accumulator that sums a fixed number of signed samples and then emits the total, saturating rather than wrapping on overflow. It sits directly upstream of the ripple adder and drives its `a`/`b`/`cin` operands. It consumes the adder's `s`/`overflow`, registers the running sum, and delivers one result per block over a valid/ready handshake.

## Interface
- `WIDTH`, 16: sample, accumulator and result width in bits (two's complement); must be >= 2.
- `COUNT`, 8: samples per block; must be >= 1.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `clear` input 1: synchronous block abort; highest priority after reset.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block accepts a sample this cycle.
- `in_data` input WIDTH: signed sample.
- `out_valid` output 1: `out_data`/`out_sat` hold a finished block.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output WIDTH: signed saturated block sum.
- `out_sat` output 1: saturation occurred at least once during this block.

## Operation
- States:
  - `ACCUM`: collecting samples.
  - `HOLD`: result presented, waiting for downstream.
- `in_ready` is 1 exactly when state is `ACCUM`; it is combinational from state only.
- Accept means `in_valid && in_ready`. On accept:
  - Adder operands are `a = acc`, `b = in_data`, `cin = 0`.
  - Next sum is `s` when `overflow == 0`.
  - When `overflow == 1`, next sum saturates: `acc[WIDTH-1] == 0` gives the max positive value (0111…1); otherwise it gives the min negative value (1000…0). `sat` is set.
  - `cnt` increments.
- Accept with `cnt == COUNT-1`:
  - `out_data` takes the next sum; `out_sat` takes `sat | overflow`.
  - `acc`, `cnt` and `sat` clear to 0; state goes to `HOLD`.
- `HOLD`: `in_ready = 0` and `in_valid` is ignored. `out_data`/`out_sat` stay stable. On `out_valid && out_ready`, state goes to `ACCUM` and `out_valid` drops.
- `clear` (synchronous):
  - `acc`, `cnt` and `sat` go to 0; state goes to `ACCUM`; `out_valid` goes to 0.
  - A sample presented in the same cycle is dropped.
  - A pending result is discarded.
- `COUNT = 1`: every accepted sample produces a result (`acc` is 0, so the result is the sample itself and `out_sat = 0`).
- `cnt` width is max(1, clog2(COUNT)); `cnt` never exceeds `COUNT-1`.

## Timing
- Reset values:
  - Internal: state `ACCUM`, `acc = 0`, `cnt = 0`, `sat = 0`.
  - Outputs: `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_sat = 0`.
  - Outputs take these values immediately on `rst_n` falling, including mid-block or in `HOLD`. Any partial block or pending result is lost.
- Throughput: one sample per cycle in `ACCUM`.
- Latency: the final sample accepted on edge t gives `out_valid = 1` from edge t onward (visible in cycle t+1).
- Minimum `HOLD` time is one cycle. `in_ready` returns to 1 in the cycle after the output handshake.
- Block period is at least `COUNT + 1` cycles.
- `out_data`, `out_sat` and `out_valid` are registered outputs; `in_ready` is a decode of registered state.
- No combinational path runs from `out_ready` or `in_valid` to any output.

## Structure
- Shared package `accum_pkg`:
  - State enum typedef (`ACCUM`, `HOLD`).
  - Saturation helper functions returning max/min WIDTH-bit signed constants.
- One sub-module: the existing `Increment` ripple adder (`a`, `b`, `cin`, `s`, `overflow`), instantiated once with `WIDTH` passed through.
- Saturation mux, counter and FSM are local to `accumulate_dump`.

## Test plan
All cases use `WIDTH = 8`, `COUNT = 4`.
- Samples 1, 2, 3, 4 back-to-back with `out_ready = 1` -> `out_valid` pulses 1 cycle after 4th accept, `out_data = 10`, `out_sat = 0`, `in_ready` low exactly one cycle.
- Samples 100, 100, -50, 10 -> running sum 100, 127 (saturated), 77, 87; result `out_data = 87`, `out_sat = 1`.
- Samples -100, -100, -100, 0 -> running sum clamps at -128; result `out_data = -128`, `out_sat = 1`; next block 1, 1, 1, 1 gives 4 with `out_sat = 0`.
- Result pending with `out_ready = 0` for 5 cycles while `in_valid = 1` -> `in_ready = 0`, outputs stable, no samples absorbed; after handshake, the next block starts from 0.
- `clear` after 2 samples (5, 5), then 1, 1, 1, 1 -> `out_data = 4`; `clear` asserted during `HOLD` -> `out_valid` drops next cycle, result discarded.
- `rst_n` pulled low asynchronously mid-block and during `HOLD` -> `out_valid = 0`, `in_ready = 1`, `out_data = 0` without waiting for a clock edge; the following block sums correctly from 0.
